fft_butterfly: RTL and testbench
================================

# fft_butterfly

Pipelined radix-2 decimation-in-time butterfly for the FFT datapath. Sits directly downstream of the twiddle ROM and consumes its registered, packed `{real, im}` twiddle output. The sequencer presents the data pair on `in_a`/`in_b` in the same cycle it drives the ROM read address. The block absorbs the ROM's one-cycle read latency internally and emits `X = A + B·W` and `Y = A − B·W` as a fully pipelined stream with no backpressure.

## Interface

Parameters:
- `word_size`, default 16: width of each real/imag component. Data and twiddles are signed Q1.(word_size−1).
- `SCALE`, default 0: when 1, both outputs are arithmetically shifted right by 1 (per-stage 1/2 scaling).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  `in_a`/`in_b` valid this cycle.
- `in_a`  input  2*word_size  packed `{re, im}` operand A.
- `in_b`  input  2*word_size  packed `{re, im}` operand B.
- `twiddle`  input  2*word_size  packed `{re, im}` twiddle. Must be the ROM output for the address issued with the corresponding `in_valid`, i.e. present one cycle after it.
- `out_valid`  output  1  `out_x`/`out_y` valid.
- `out_x`  output  2*word_size  packed `{re, im}` A + B·W.
- `out_y`  output  2*word_size  packed `{re, im}` A − B·W.

## Operation

- **S0, edge E0:** register `in_a`, `in_b`, `in_valid`.
- **S1, edge E1:** register `twiddle` alongside the S0 data. This is the ROM-latency alignment stage.
- **S2, edge E2:** four signed products, each 2*word_size bits: br·wr, bi·wi, br·wi, bi·wr.
- **S3, edge E3:** form B·W.
  - pr = br·wr − bi·wi and pi = br·wi + bi·wr, each 2*word_size+1 bits.
  - Add rounding constant 2^(word_size−2), then arithmetic shift right by word_size−1.
  - Keep the result to word_size+2 bits.
  - W = −1.0 (0x8000 at 16 bits) is legal. (−1)·(−1) must yield +1.0 without internal wrap.
- **S4, edge E4:** form the outputs.
  - Compute A ± B·W in word_size+2 bits.
  - If SCALE=1, arithmetic shift right by 1 (floor).
  - Reduce to word_size per component according to Configuration.
  - Register into `out_x`/`out_y`, with `out_valid` = S3 valid.
- Valid bits travel with the data through every stage. Data registers may load unconditionally; only `out_valid` qualifies the output.
- There is no state machine and no stall: one result per accepted input, in order. Input gaps are reproduced as identical output gaps.

## Timing

- Latency: an input sampled at E0 appears on the outputs after E4, so `out_valid` is high in the cycle following E4 (4-cycle latency).
- Throughput: 1 butterfly per clock. Back-to-back `in_valid` is always accepted.
- `twiddle` is sampled exactly one edge after its data. Skew by the sequencer is a sequencer bug and is not detected here.
- Reset values: all valid bits, `out_valid`, `out_x`, `out_y` and all pipeline registers are 0.
- Reset mid-stream: outputs and valids clear immediately, without waiting for a clock edge. In-flight data is discarded.
  - After `rst` deasserts, `out_valid` stays 0 until 4 cycles after the first new `in_valid`.
  - An `in_valid` on the first edge after release is accepted.

## Configuration

- `BUTTERFLY_SATURATE_EN`:
  - **Defined:** each output component saturates to the range [−2^(word_size−1), 2^(word_size−1)−1], i.e. 0x8000..0x7FFF at 16 bits.
  - **Undefined:** each component is two's-complement truncated to its low word_size bits (wraps).
- The macro affects S4 only. Latency and all other behaviour are unchanged.

## Test plan

All scenarios use word_size=16.

- **Unity twiddle.** SCALE=0, W=0x7FFF+j0, A=0x1000+j0, B=0x0800+j0 → `out_x`=0x1800+j0, `out_y`=0x0800+j0.
- **−j twiddle.** SCALE=0, W=0x0000+j0x8000, A=0, B=0x0100+j0 → `out_x`=0x0000+j0xFF00, `out_y`=0x0000+j0x0100.
- **Overflow.** W=0x8000+j0, A=0x7000+j0, B=0x7000+j0 → `out_x`=0x0000. `out_y`=0x7FFF with `BUTTERFLY_SATURATE_EN` defined, 0xE000 without it.
- **Scaling.** SCALE=1 with the unity-twiddle vector → `out_x`=0x0C00+j0, `out_y`=0x0400+j0.
- **Streaming.** 32 back-to-back inputs driven from a real twiddle ROM (N=32), then a 3-cycle gap, then 5 more → results match a reference model in order. `out_valid` first rises 4 cycles after the first input, with the 3-cycle gap preserved.
- **Reset mid-stream.** Assert `rst` asynchronously between edges during streaming → `out_valid`, `out_x`, `out_y` go to 0 immediately. After release, no stale results appear; the first new output has 4-cycle latency.

Source files
------------

// File: rtl/fft_butterfly.sv
// Pipelined radix-2 DIT butterfly: X = A + B*W, Y = A - B*W, 4-cycle latency.
// Define BUTTERFLY_SATURATE_EN for saturating outputs; by default the outputs wrap.
module fft_butterfly #(
   parameter int word_size = 16,
   parameter int SCALE     = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [2*word_size-1:0] in_a,
   input  logic [2*word_size-1:0] in_b,
   input  logic [2*word_size-1:0] twiddle,
   output logic                   out_valid,
   output logic [2*word_size-1:0] out_x,
   output logic [2*word_size-1:0] out_y
);

   localparam int CW = 2 * word_size;       // packed complex word
   localparam int PW = 2 * word_size;       // single product
   localparam int SW = 2 * word_size + 1;   // product sum/difference
   localparam int BW = word_size + 2;       // B*W and A +/- B*W

   localparam logic signed [SW-1:0] RND     = SW'(1) << (word_size - 2);
   localparam logic signed [BW-1:0] SAT_MAX = BW'((1 << (word_size - 1)) - 1);
   localparam logic signed [BW-1:0] SAT_MIN = -BW'(1 << (word_size - 1));

   // S0: input capture
   logic [CW-1:0] a0_reg, b0_reg;
   logic          v0_reg;
   // S1: twiddle alignment (ROM read latency)
   logic [CW-1:0] a1_reg, b1_reg, w1_reg;
   logic          v1_reg;
   // S2: partial products
   logic [CW-1:0]        a2_reg;
   logic                 v2_reg;
   logic signed [PW-1:0] p_rr_reg, p_ii_reg, p_ri_reg, p_ir_reg;
   // S3: rounded B*W, {re, im}
   logic [CW-1:0]   a3_reg;
   logic            v3_reg;
   logic [2*BW-1:0] bw_reg;
   // S4: outputs
   logic [CW-1:0] x_reg, y_reg;
   logic          v4_reg;

   logic signed [word_size-1:0] b_re, b_im, w_re, w_im;
   logic signed [SW-1:0]        pr_full, pi_full;
   logic [CW-1:0]               x_next, y_next;

   assign b_re = b1_reg[CW-1 -: word_size];
   assign b_im = b1_reg[word_size-1:0];
   assign w_re = w1_reg[CW-1 -: word_size];
   assign w_im = w1_reg[word_size-1:0];

   // One extra bit so that (-1)*(-1) + (-1)*(-1) cannot wrap before rounding.
   assign pr_full = SW'(p_rr_reg) - SW'(p_ii_reg);
   assign pi_full = SW'(p_ri_reg) + SW'(p_ir_reg);

   function automatic logic [word_size-1:0] reduce(input logic signed [BW-1:0] v);
`ifdef BUTTERFLY_SATURATE_EN
      if (v > SAT_MAX)
         return word_size'(SAT_MAX);
      else if (v < SAT_MIN)
         return word_size'(SAT_MIN);
      else
         return word_size'(v);
`else
      return word_size'(v);
`endif
   endfunction

   // Component 1 is real, component 0 is imaginary, matching the {re, im} packing.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_comp
         logic signed [BW-1:0] a_c, bw_c, sum_x, sum_y, sc_x, sc_y;

         assign a_c   = BW'($signed(a3_reg[gi*word_size +: word_size]));
         assign bw_c  = $signed(bw_reg[gi*BW +: BW]);
         assign sum_x = a_c + bw_c;
         assign sum_y = a_c - bw_c;
         assign sc_x  = (SCALE != 0) ? (sum_x >>> 1) : sum_x;
         assign sc_y  = (SCALE != 0) ? (sum_y >>> 1) : sum_y;

         assign x_next[gi*word_size +: word_size] = reduce(sc_x);
         assign y_next[gi*word_size +: word_size] = reduce(sc_y);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a0_reg   <= '0;
         b0_reg   <= '0;
         v0_reg   <= 1'b0;
         a1_reg   <= '0;
         b1_reg   <= '0;
         w1_reg   <= '0;
         v1_reg   <= 1'b0;
         a2_reg   <= '0;
         v2_reg   <= 1'b0;
         p_rr_reg <= '0;
         p_ii_reg <= '0;
         p_ri_reg <= '0;
         p_ir_reg <= '0;
         a3_reg   <= '0;
         v3_reg   <= 1'b0;
         bw_reg   <= '0;
         x_reg    <= '0;
         y_reg    <= '0;
         v4_reg   <= 1'b0;
      end else begin
         a0_reg   <= in_a;
         b0_reg   <= in_b;
         v0_reg   <= in_valid;

         a1_reg   <= a0_reg;
         b1_reg   <= b0_reg;
         w1_reg   <= twiddle;
         v1_reg   <= v0_reg;

         a2_reg   <= a1_reg;
         v2_reg   <= v1_reg;
         p_rr_reg <= PW'(b_re) * PW'(w_re);
         p_ii_reg <= PW'(b_im) * PW'(w_im);
         p_ri_reg <= PW'(b_re) * PW'(w_im);
         p_ir_reg <= PW'(b_im) * PW'(w_re);

         a3_reg   <= a2_reg;
         v3_reg   <= v2_reg;
         bw_reg   <= {BW'((pr_full + RND) >>> (word_size - 1)),
                      BW'((pi_full + RND) >>> (word_size - 1))};

         x_reg    <= x_next;
         y_reg    <= y_next;
         v4_reg   <= v3_reg;
      end
   end

   assign out_valid = v4_reg;
   assign out_x     = x_reg;
   assign out_y     = y_reg;

endmodule

// File: tb/tb_fft_butterfly.sv
// Self-checking bench for fft_butterfly (word_size=16), SCALE=0 and SCALE=1 instances side by side.
module tb_fft_butterfly;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_a, in_b, twiddle;
   logic        v0, v1;
   logic [31:0] x0, y0, x1, y1;

   int          n_checks = 0;
   int          n_errors = 0;
   int          edge_n   = 0;
   int          valid_base;
   logic [31:0] next_tw;
   logic [31:0] tw [32];

   bit          rec_v  [1024];
   logic [31:0] rec_x0 [1024];
   logic [31:0] rec_y0 [1024];
   logic [31:0] rec_x1 [1024];
   logic [31:0] rec_y1 [1024];

   always #5 clk = ~clk;

   fft_butterfly #(.word_size(16), .SCALE(0)) dut_s0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
      .twiddle(twiddle), .out_valid(v0), .out_x(x0), .out_y(y0)
   );

   fft_butterfly #(.word_size(16), .SCALE(1)) dut_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
      .twiddle(twiddle), .out_valid(v1), .out_x(x1), .out_y(y1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   function automatic longint s16(input logic [15:0] v);
      return longint'($signed(v));
   endfunction

   function automatic logic [15:0] red(input longint v);
`ifdef BUTTERFLY_SATURATE_EN
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
`endif
      return 16'(v);
   endfunction

   // Reference butterfly in plain integer arithmetic
   function automatic logic [31:0] bf(input logic [31:0] a, b, w, input bit minus, input bit scale);
      longint ar, ai, br, bi, wr, wi, pr, pi, xr, xi;
      ar = s16(a[31:16]); ai = s16(a[15:0]);
      br = s16(b[31:16]); bi = s16(b[15:0]);
      wr = s16(w[31:16]); wi = s16(w[15:0]);
      pr = (br * wr - bi * wi + 16384) >>> 15;
      pi = (br * wi + bi * wr + 16384) >>> 15;
      xr = minus ? ar - pr : ar + pr;
      xi = minus ? ai - pi : ai + pi;
      if (scale) begin
         xr = xr >>> 1;
         xi = xi >>> 1;
      end
      return {red(xr), red(xi)};
   endfunction

   // One clock: drive at negedge, record at posedge, check at next negedge.
   task automatic step(input bit v, input logic [31:0] a, b, w);
      int idx;
      bit ev;
      in_valid = v;
      in_a     = a;
      in_b     = b;
      twiddle  = next_tw;
      next_tw  = w;
      @(posedge clk);
      edge_n++;
      rec_v[edge_n]  = v;
      rec_x0[edge_n] = bf(a, b, w, 1'b0, 1'b0);
      rec_y0[edge_n] = bf(a, b, w, 1'b1, 1'b0);
      rec_x1[edge_n] = bf(a, b, w, 1'b0, 1'b1);
      rec_y1[edge_n] = bf(a, b, w, 1'b1, 1'b1);
      @(negedge clk);
      idx = edge_n - 4;
      ev  = (idx >= valid_base) && rec_v[idx];
      check("valid_s0", {31'b0, v0}, {31'b0, ev});
      check("valid_s1", {31'b0, v1}, {31'b0, ev});
      if (ev) begin
         check("x_s0", x0, rec_x0[idx]);
         check("y_s0", y0, rec_y0[idx]);
         check("x_s1", x1, rec_x1[idx]);
         check("y_s1", y1, rec_y1[idx]);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   // Hold reset for two edges and release at a negedge.
   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rst_valid_s0", {31'b0, v0}, 32'h0);
      check("rst_valid_s1", {31'b0, v1}, 32'h0);
      check("rst_x_s0", x0, 32'h0);
      check("rst_y_s0", y0, 32'h0);
      check("rst_x_s1", x1, 32'h0);
      check("rst_y_s1", y1, 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         edge_n++;
         rec_v[edge_n] = 1'b0;
      end
      @(negedge clk);
      rst        = 1'b0;
      valid_base = edge_n + 1;
      next_tw    = 32'h0;
   endtask

   // Single vector, then flush until its result is on the outputs.
   task automatic directed(input string tag, input logic [31:0] a, b, w,
                           input logic [31:0] ex0, ey0, ex1, ey1);
      step(1'b1, a, b, w);
      idle(4);
      check({tag, "_x_s0"}, x0, ex0);
      check({tag, "_y_s0"}, y0, ey0);
      check({tag, "_x_s1"}, x1, ex1);
      check({tag, "_y_s1"}, y1, ey1);
   endtask

   initial begin
      logic [31:0] ovf_y0;
      logic [31:0] mm_x0;
      for (int k = 0; k < 32; k++) begin
         real ang;
         int  re, im;
         ang   = 2.0 * 3.14159265358979 * k / 32.0;
         re    = int'(32767.0 * $cos(ang));
         im    = int'(-32767.0 * $sin(ang));
         tw[k] = {16'(re), 16'(im)};
      end
`ifdef BUTTERFLY_SATURATE_EN
      ovf_y0 = 32'h7FFF_0000;
      mm_x0  = 32'h7FFF_0000;
`else
      ovf_y0 = 32'hE000_0000;
      mm_x0  = 32'h8000_0000;
`endif
      in_a = '0; in_b = '0; twiddle = '0; next_tw = '0; in_valid = 1'b0;
      valid_base = 1;
      #2;
      do_reset();

      directed("unity", 32'h1000_0000, 32'h0800_0000, 32'h7FFF_0000,
               32'h1800_0000, 32'h0800_0000, 32'h0C00_0000, 32'h0400_0000);
      directed("minus_j", 32'h0000_0000, 32'h0100_0000, 32'h0000_8000,
               32'h0000_FF00, 32'h0000_0100, 32'h0000_FF80, 32'h0000_0080);
      directed("overflow", 32'h7000_0000, 32'h7000_0000, 32'h8000_0000,
               32'h0000_0000, ovf_y0, 32'h0000_0000, 32'h7000_0000);
      directed("neg1_sq", 32'h0000_0000, 32'h8000_0000, 32'h8000_0000,
               mm_x0, 32'h8000_0000, 32'h4000_0000, 32'hC000_0000);

      // Streaming: 32 back-to-back from the ROM, 3-cycle gap, 5 more
      for (int k = 0; k < 32; k++) step(1'b1, $urandom(), $urandom(), tw[k]);
      idle(3);
      for (int k = 0; k < 5; k++) step(1'b1, $urandom(), $urandom(), tw[$urandom_range(0, 31)]);
      idle(5);

      // Reset mid-stream, between edges, with results in flight
      for (int k = 0; k < 6; k++) step(1'b1, $urandom(), $urandom(), tw[k]);
      #2;
      do_reset();
      for (int k = 0; k < 8; k++) step(1'b1, $urandom(), $urandom(), tw[31 - k]);
      step(1'b0, 32'h0, 32'h0, 32'h0);
      for (int k = 0; k < 4; k++) step(1'b1, $urandom(), $urandom(), tw[$urandom_range(0, 31)]);
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
